// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - IF/EX-side signal bundle between the pipeline and the branch predictor
interface branch_predictor_if;
  // IF-stage lookup
  logic [31:0] pc_IF;
  logic        stall;
  logic        predtaken_IF;
  logic [31:0] pcpred_IF;
  // EX-stage resolution
  logic [31:0] pc_EX;
  logic        branch_EX;
  logic        btaken_EX;
  logic        jal_EX;
  logic        jalr_EX;
  logic [31:0] ctarget;
  logic [31:0] pcimm_EX;
  logic        mispredict;
  logic [31:0] redirect_pc;

  // Pipeline side: drives fetch/EX information, consumes prediction and redirect
  modport master (
    output pc_IF, stall, pc_EX, branch_EX, btaken_EX, jal_EX, jalr_EX, ctarget, pcimm_EX,
    input  predtaken_IF, pcpred_IF, mispredict, redirect_pc
  );

  // Predictor side
  modport slave (
    input  pc_IF, stall, pc_EX, branch_EX, btaken_EX, jal_EX, jalr_EX, ctarget, pcimm_EX,
    output predtaken_IF, pcpred_IF, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, prediction pipe and EX resolution
module branch_predictor #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input logic               clk,
  input logic               rstn,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  // Branch target table
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic             jmp_q    [ENTRIES];

  // Prediction pipe: slot 1 = IF->ID, slot 2 = ID->EX
  logic        s1_v, s1_pt;
  logic [31:0] s1_tgt;
  logic        s2_v, s2_pt;
  logic [31:0] s2_tgt;

  // Lookup and resolution nets
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             pred_taken;
  logic [31:0]      pred_pc;
  logic [31:0]      ex_pc4;
  logic [31:0]      ex_redirect;
  logic [31:0]      ex_predicted;
  logic             ex_mispredict;
  logic             ex_jump;

  assign if_idx = bp.pc_IF[IDX_W+1:2];
  assign if_tag = bp.pc_IF[31:IDX_W+2];
  assign ex_idx = bp.pc_EX[IDX_W+1:2];
  assign ex_tag = bp.pc_EX[31:IDX_W+2];

  // Fetch-side lookup: reads the pre-edge table contents, so a same-cycle update is not visible
  always_comb begin
    if_hit     = 1'b0;
    pred_taken = 1'b0;
    pred_pc    = bp.pc_IF + 32'd4;
    if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken = if_hit && (jmp_q[if_idx] || cnt_q[if_idx][1]);
    if (pred_taken) begin
      pred_pc = target_q[if_idx];
    end
  end

  assign bp.predtaken_IF = pred_taken;
  assign bp.pcpred_IF    = pred_pc;

  // EX-side resolution: the true next PC compared against what was predicted two stages ago
  always_comb begin
    ex_jump       = bp.jal_EX || bp.jalr_EX;
    ex_pc4        = bp.pc_EX + 32'd4;
    ex_redirect   = ex_pc4;
    ex_predicted  = ex_pc4;
    ex_mispredict = 1'b0;
    ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    if (ex_jump) begin
      ex_redirect = bp.pcimm_EX;
    end else if (bp.branch_EX) begin
      ex_redirect = bp.ctarget;
    end
    if (s2_pt) begin
      ex_predicted = s2_tgt;
    end
    ex_mispredict = s2_v && (ex_predicted != ex_redirect);
  end

  assign bp.mispredict  = ex_mispredict;
  assign bp.redirect_pc = ex_redirect;

  // Prediction pipe: flush beats stall; stall holds IF->ID and bubbles ID->EX
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v   <= 1'b0;
      s1_pt  <= 1'b0;
      s1_tgt <= 32'd0;
      s2_v   <= 1'b0;
      s2_pt  <= 1'b0;
      s2_tgt <= 32'd0;
    end else if (ex_mispredict) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (bp.stall) begin
      s2_v <= 1'b0;
    end else begin
      s1_v   <= 1'b1;
      s1_pt  <= pred_taken;
      s1_tgt <= pred_pc;
      s2_v   <= s1_v;
      s2_pt  <= s1_pt;
      s2_tgt <= s1_tgt;
    end
  end

  // Table training from the resolved EX instruction; bubbles never touch the table
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        cnt_q[i]    <= 2'b01;
        jmp_q[i]    <= 1'b0;
      end
    end else if (s2_v) begin
      if (ex_jump) begin
        // Unconditional jumps always claim the slot, evicting whatever aliased there
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bp.pcimm_EX;
        jmp_q[ex_idx]    <= 1'b1;
      end else if (bp.branch_EX) begin
        if (ex_hit) begin
          jmp_q[ex_idx] <= 1'b0;
          if (bp.btaken_EX) begin
            target_q[ex_idx] <= bp.ctarget;
            if (cnt_q[ex_idx] != 2'b11) begin
              cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
            end
          end else if (cnt_q[ex_idx] != 2'b00) begin
            cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
          end
        end else if (bp.btaken_EX) begin
          // Only taken branches earn an entry; never-taken ones would just predict pc+4 anyway
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= bp.ctarget;
          cnt_q[ex_idx]    <= CNT_INIT;
          jmp_q[ex_idx]    <= 1'b0;
        end
      end else if (ex_hit) begin
        // A non-control instruction matched an entry: stale alias, drop it
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  localparam logic [31:0] FILL = 32'h2000_0020;

  logic clk;
  logic rstn;
  int   ncmp;
  int   nfail;

  branch_predictor_if bp ();

  branch_predictor #(.IDX_W(4), .CNT_INIT(2'b10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bp   (bp)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic br, input logic bt, input logic jal,
                        input logic jalr, input logic [31:0] ctgt, input logic [31:0] pcimm);
    bp.pc_EX     = pc;
    bp.branch_EX = br;
    bp.btaken_EX = bt;
    bp.jal_EX    = jal;
    bp.jalr_EX   = jalr;
    bp.ctarget   = ctgt;
    bp.pcimm_EX  = pcimm;
  endtask

  task automatic ex_fill();
    set_ex(FILL, 1'b0, 1'b0, 1'b0, 1'b0, FILL + 32'd4, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch pc, let it travel to EX behind a filler, then resolve it there
  task automatic run_instr(input string tag, input logic [31:0] pc, input logic br, input logic bt,
                           input logic jal, input logic jalr, input logic [31:0] ctgt,
                           input logic [31:0] pcimm, input logic exp_pt, input logic [31:0] exp_pp,
                           input logic exp_mis, input logic [31:0] exp_rd);
    bp.stall = 1'b0;
    bp.pc_IF = pc;
    ex_fill();
    #1;
    chk({tag, ".predtaken"}, {31'd0, bp.predtaken_IF}, {31'd0, exp_pt});
    chk({tag, ".pcpred"}, bp.pcpred_IF, exp_pp);
    tick();
    bp.pc_IF = FILL;
    ex_fill();
    tick();
    set_ex(pc, br, bt, jal, jalr, ctgt, pcimm);
    #1;
    chk({tag, ".mispredict"}, {31'd0, bp.mispredict}, {31'd0, exp_mis});
    chk({tag, ".redirect"}, bp.redirect_pc, exp_rd);
    tick();
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    rstn  = 1'b0;
    bp.stall = 1'b0;
    bp.pc_IF = 32'h40;
    ex_fill();
    #1;
    // 1 cold
    chk("rst.predtaken", {31'd0, bp.predtaken_IF}, 32'd0);
    chk("rst.pcpred", bp.pcpred_IF, 32'h44);
    chk("rst.mispredict", {31'd0, bp.mispredict}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    run_instr("cold", 32'h40, 0, 0, 0, 0, 32'h44, 0, 1'b0, 32'h44, 1'b0, 32'h44);

    // 2 taken branch 0x40 -> 0x80
    run_instr("br1", 32'h40, 1, 1, 0, 0, 32'h80, 0, 1'b0, 32'h44, 1'b1, 32'h80);
    chk("br1.cnt", {30'd0, dut.cnt_q[0]}, 32'd2);
    run_instr("br2", 32'h40, 1, 1, 0, 0, 32'h80, 0, 1'b1, 32'h80, 1'b0, 32'h80);

    // 3 counter walk on 0x44 (index 1)
    run_instr("c.alloc", 32'h44, 1, 1, 0, 0, 32'h90, 0, 1'b0, 32'h48, 1'b1, 32'h90);
    chk("c.alloc.cnt", {30'd0, dut.cnt_q[1]}, 32'd2);
    run_instr("c.nt1", 32'h44, 1, 0, 0, 0, 32'h48, 0, 1'b1, 32'h90, 1'b1, 32'h48);
    chk("c.nt1.cnt", {30'd0, dut.cnt_q[1]}, 32'd1);
    run_instr("c.nt2", 32'h44, 1, 0, 0, 0, 32'h48, 0, 1'b0, 32'h48, 1'b0, 32'h48);
    chk("c.nt2.cnt", {30'd0, dut.cnt_q[1]}, 32'd0);
    run_instr("c.nt3", 32'h44, 1, 0, 0, 0, 32'h48, 0, 1'b0, 32'h48, 1'b0, 32'h48);
    chk("c.nt3.cnt", {30'd0, dut.cnt_q[1]}, 32'd0);
    run_instr("c.t1", 32'h44, 1, 1, 0, 0, 32'h90, 0, 1'b0, 32'h48, 1'b1, 32'h90);
    chk("c.t1.cnt", {30'd0, dut.cnt_q[1]}, 32'd1);
    run_instr("c.t2", 32'h44, 1, 1, 0, 0, 32'h90, 0, 1'b0, 32'h48, 1'b1, 32'h90);
    chk("c.t2.cnt", {30'd0, dut.cnt_q[1]}, 32'd2);
    run_instr("c.t3", 32'h44, 1, 1, 0, 0, 32'h90, 0, 1'b1, 32'h90, 1'b0, 32'h90);
    chk("c.t3.cnt", {30'd0, dut.cnt_q[1]}, 32'd3);

    // 4 JAL 0x100 -> 0x200, then JALR retarget to 0x300
    run_instr("jal1", 32'h100, 0, 0, 1, 0, 32'h104, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    run_instr("jal2", 32'h100, 0, 0, 1, 0, 32'h104, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    chk("jal.jmp", {31'd0, dut.jmp_q[0]}, 32'd1);
    run_instr("jalr1", 32'h100, 0, 0, 0, 1, 32'h104, 32'h300, 1'b1, 32'h200, 1'b1, 32'h300);
    run_instr("jalr2", 32'h100, 0, 0, 0, 1, 32'h104, 32'h300, 1'b1, 32'h300, 1'b0, 32'h300);

    // 5 alias: non-control at a predicted-taken pc
    run_instr("al.br", 32'h40, 1, 1, 0, 0, 32'h80, 0, 1'b0, 32'h44, 1'b1, 32'h80);
    run_instr("al.nc", 32'h40, 0, 0, 0, 0, 32'h44, 0, 1'b1, 32'h80, 1'b1, 32'h44);
    chk("al.valid", {31'd0, dut.valid_q[0]}, 32'd0);
    run_instr("al.after", 32'h40, 0, 0, 0, 0, 32'h44, 0, 1'b0, 32'h44, 1'b0, 32'h44);

    // 6a stall while a predicted-taken branch sits in IF->ID
    bp.pc_IF = 32'h44;
    ex_fill();
    #1;
    chk("st.predtaken", {31'd0, bp.predtaken_IF}, 32'd1);
    tick();
    bp.stall = 1'b1;
    tick();
    bp.stall = 1'b0;
    bp.pc_IF = FILL;
    set_ex(32'h44, 0, 0, 0, 0, 32'h48, 0);
    #1;
    chk("st.bubble.mispredict", {31'd0, bp.mispredict}, 32'd0);
    tick();
    set_ex(32'h44, 1, 1, 0, 0, 32'h90, 0);
    #1;
    chk("st.br.mispredict", {31'd0, bp.mispredict}, 32'd0);
    tick();

    // 6b mispredict and stall in the same cycle
    bp.pc_IF = 32'h44;
    ex_fill();
    tick();
    bp.pc_IF = FILL;
    tick();
    set_ex(32'h44, 1, 0, 0, 0, 32'h48, 0);
    bp.stall = 1'b1;
    #1;
    chk("ms.mispredict", {31'd0, bp.mispredict}, 32'd1);
    chk("ms.redirect", bp.redirect_pc, 32'h48);
    tick();
    chk("ms.s1_v", {31'd0, dut.s1_v}, 32'd0);
    chk("ms.s2_v", {31'd0, dut.s2_v}, 32'd0);
    chk("ms.cnt", {30'd0, dut.cnt_q[1]}, 32'd2);
    bp.stall = 1'b0;
    set_ex(32'h44, 0, 0, 0, 0, 32'h48, 0);
    #1;
    chk("ms.next.mispredict", {31'd0, bp.mispredict}, 32'd0);
    tick();
    bp.pc_IF = 32'h44;
    ex_fill();
    #1;
    chk("ms.keep.predtaken", {31'd0, bp.predtaken_IF}, 32'd1);
    chk("ms.keep.pcpred", bp.pcpred_IF, 32'h90);

    // 6c asynchronous reset mid-run wipes the table
    rstn = 1'b0;
    #1;
    chk("mr.predtaken", {31'd0, bp.predtaken_IF}, 32'd0);
    chk("mr.pcpred", bp.pcpred_IF, 32'h48);
    chk("mr.mispredict", {31'd0, bp.mispredict}, 32'd0);
    tick();
    rstn = 1'b1;
    bp.pc_IF = 32'h100;
    #1;
    chk("mr.jal.predtaken", {31'd0, bp.predtaken_IF}, 32'd0);
    chk("mr.jal.pcpred", bp.pcpred_IF, 32'h104);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
